rank_insert_arb: RTL and testbench
==================================

RANK_INSERT_ARB -- requirements
Module: rank_insert_arb

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4: number of requesting input ports (2..8).
REQ-002 The block SHALL have parameter FLOW_ID_WIDTH, default 16: flow identifier width.
REQ-003 The block SHALL have parameter MAX_NUM_FLOWS, default 4: flowIDs at or above this value are illegal.
REQ-004 The block SHALL have parameter META_WIDTH, default 16: metadata width.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, NUM_PORTS: per-port insert request.
REQ-008 The block SHALL have port req_flowID, input, NUM_PORTS*FLOW_ID_WIDTH: per-port flowID; port p occupies slice p.
REQ-009 The block SHALL have port req_meta, input, NUM_PORTS*META_WIDTH: per-port metadata; port p occupies slice p.
REQ-010 The block SHALL have port req_ready, output, NUM_PORTS: one-hot grant; at most one bit is high per cycle.
REQ-011 The block SHALL have port busy, input, 1: rank-stage backpressure (FIFO nearly full).
REQ-012 The block SHALL have port insert, output, 1: single-cycle insert strobe to the rank stage.
REQ-013 The block SHALL have port flowID_out, output, FLOW_ID_WIDTH: flowID qualified by insert.
REQ-014 The block SHALL have port meta_out, output, META_WIDTH: metadata qualified by insert.
REQ-015 The block SHALL have port drop_count, output, 16: saturating count of illegal-flowID requests.
REQ-016 The block SHALL have port insert_count, output, 32: wrapping count of inserts issued.

Function
REQ-017 A transfer on port p SHALL occur in a cycle where req_valid[p] and req_ready[p] are both high.
REQ-018 req_ready SHALL be combinational from req_valid, busy and the priority pointer; req_ready SHALL be all-zero when busy is high or no port is valid.
REQ-019 The grant SHALL go to the first valid port at or after the priority pointer, searching upward modulo NUM_PORTS.
REQ-020 After a grant to port p, the pointer SHALL become (p+1) mod NUM_PORTS; with no grant, the pointer SHALL hold.
REQ-021 A legal transfer (flowID < MAX_NUM_FLOWS) in cycle N SHALL produce insert=1 with that flowID and meta in cycle N+1, through registered outputs.
REQ-022 insert SHALL be high for exactly one cycle per legal transfer; flowID_out and meta_out SHALL hold their last value when insert is low.
REQ-023 An illegal transfer SHALL be accepted (ready asserted), SHALL NOT produce insert, and SHALL increment drop_count, which saturates at 0xFFFF.
REQ-024 insert_count SHALL increment by 1 in every cycle insert is high and wrap from 0xFFFFFFFF to 0.
REQ-025 busy is nearly-full: a grant in the cycle busy rises still issues its insert in the next cycle; no grant SHALL occur while busy is high.
REQ-026 A valid request not granted SHALL keep its data stable; the arbiter SHALL NOT depend on a requester dropping req_valid.
REQ-027 With all ports continuously valid and busy low, grants SHALL rotate 0,1,...,NUM_PORTS-1 with one insert per cycle (full throughput).

Reset
REQ-028 While rst is high: insert=0, req_ready=0, flowID_out=0, meta_out=0, drop_count=0, insert_count=0, pointer=0.
REQ-029 Reset asserted mid-transfer SHALL discard any registered insert; the first grant after release SHALL honour REQ-019 with pointer 0.

Structure
REQ-030 FLOW_ID_WIDTH, META_WIDTH, MAX_NUM_FLOWS defaults and the counter widths SHALL live in the shared rank-pipe package used by the rank modules.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant); all registers stay in rank_insert_arb.

Verification
REQ-032 Ports 0..3 valid every cycle, flowIDs 0..3, busy=0 -> insert every cycle from cycle 1, flowID_out sequence 0,1,2,3,0,...; insert_count=8 after 8 grants.
REQ-033 Only ports 1 and 3 valid, pointer 2 -> first grant port 3, then port 1, then port 3.
REQ-034 Port 2 sends flowID 7 (MAX_NUM_FLOWS=4) -> req_ready[2]=1, no insert next cycle, drop_count=1; 65536 such requests -> drop_count stays 0xFFFF.
REQ-035 busy raised in the cycle of grant to port 0 -> insert for port 0 next cycle; no req_ready while busy high; on busy low, grant goes to port 1.
REQ-036 rst asserted one cycle after a legal grant -> insert stays 0, counters 0; after release, port 0 granted first.

Source files
------------

// File: rtl/rank_insert_arb_pkg.sv
// ---------------------------------------------------------------------------
// rank_insert_arb_pkg : shared rank-pipe widths, defaults and counter limits
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rank_insert_arb_pkg;
  localparam int FLOW_ID_WIDTH_DEF = 16;
  localparam int META_WIDTH_DEF    = 16;
  localparam int MAX_NUM_FLOWS_DEF = 4;
  localparam int DROP_CNT_WIDTH    = 16;
  localparam int INSERT_CNT_WIDTH  = 32;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first request at/after ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_PORTS-1:0] grant
);

  logic                 found;
  int                   sum;
  logic [PTR_WIDTH-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // Wrap the search index modulo NUM_PORTS, which need not be a power of two.
      sum = int'(ptr) + i;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      idx = PTR_WIDTH'(sum);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rank_insert_arb.sv
// ---------------------------------------------------------------------------
// rank_insert_arb : round-robin insert arbiter feeding the rank stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rank_insert_arb
  import rank_insert_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int FLOW_ID_WIDTH = FLOW_ID_WIDTH_DEF,
  parameter int MAX_NUM_FLOWS = MAX_NUM_FLOWS_DEF,
  parameter int META_WIDTH    = META_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*FLOW_ID_WIDTH-1:0] req_flowID,
  input  logic [NUM_PORTS*META_WIDTH-1:0] req_meta,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic                            busy,
  output logic                            insert,
  output logic [FLOW_ID_WIDTH-1:0]        flowID_out,
  output logic [META_WIDTH-1:0]           meta_out,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count,
  output logic [INSERT_CNT_WIDTH-1:0]     insert_count
);

  localparam int PTR_WIDTH = $clog2(NUM_PORTS);
  localparam logic [FLOW_ID_WIDTH:0] FLOW_LIMIT = (FLOW_ID_WIDTH+1)'(MAX_NUM_FLOWS);

  logic [PTR_WIDTH-1:0]     ptr;
  logic [PTR_WIDTH-1:0]     grant_idx;
  logic [NUM_PORTS-1:0]     req_masked;
  logic [NUM_PORTS-1:0]     grant;
  logic [FLOW_ID_WIDTH-1:0] sel_flow;
  logic [META_WIDTH-1:0]    sel_meta;
  logic                     any_grant;
  logic                     legal;

  // Backpressure and reset both suppress every grant.
  assign req_masked = (busy || rst) ? '0 : req_valid;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rr_arbiter (
    .req   (req_masked),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign legal     = {1'b0, sel_flow} < FLOW_LIMIT;

  always_comb begin
    grant_idx = '0;
    sel_flow  = '0;
    sel_meta  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        grant_idx = PTR_WIDTH'(p);
        sel_flow  = req_flowID[p*FLOW_ID_WIDTH +: FLOW_ID_WIDTH];
        sel_meta  = req_meta[p*META_WIDTH +: META_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      insert       <= 1'b0;
      flowID_out   <= '0;
      meta_out     <= '0;
      drop_count   <= '0;
      insert_count <= '0;
    end else begin
      insert <= any_grant && legal;
      if (any_grant && legal) begin
        flowID_out <= sel_flow;
        meta_out   <= sel_meta;
      end
      if (any_grant && !legal && (drop_count != DROP_CNT_MAX)) begin
        drop_count <= drop_count + 1'b1;
      end
      if (insert) begin
        insert_count <= insert_count + 1'b1;
      end
      if (any_grant) begin
        ptr <= (grant_idx == PTR_WIDTH'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rank_insert_arb.sv
// ---------------------------------------------------------------------------
// tb_rank_insert_arb : directed self-checking bench for rank_insert_arb
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rank_insert_arb;

  localparam int NP = 4;
  localparam int FW = 16;
  localparam int MW = 16;

  logic           clk;
  logic           rst;
  logic [NP-1:0]  req_valid;
  logic [NP*FW-1:0] req_flowID;
  logic [NP*MW-1:0] req_meta;
  logic [NP-1:0]  req_ready;
  logic           busy;
  logic           insert;
  logic [FW-1:0]  flowID_out;
  logic [MW-1:0]  meta_out;
  logic [15:0]    drop_count;
  logic [31:0]    insert_count;

  int checks = 0;
  int errors = 0;
  int inserts_seen = 0;

  rank_insert_arb #(
    .NUM_PORTS     (NP),
    .FLOW_ID_WIDTH (FW),
    .MAX_NUM_FLOWS (4),
    .META_WIDTH    (MW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_flowID   (req_flowID),
    .req_meta     (req_meta),
    .req_ready    (req_ready),
    .busy         (busy),
    .insert       (insert),
    .flowID_out   (flowID_out),
    .meta_out     (meta_out),
    .drop_count   (drop_count),
    .insert_count (insert_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_fid(input int p, input logic [FW-1:0] v);
    req_flowID[p*FW +: FW] = v;
  endtask

  task automatic chk_ins(input string tag, input logic [FW-1:0] fid);
    chk({tag, "_insert"}, 32'(insert), 32'd1);
    chk({tag, "_flow"}, 32'(flowID_out), 32'(fid));
    chk({tag, "_meta"}, 32'(meta_out), 32'(16'hA0 + fid));
  endtask

  initial begin
    rst        = 1'b1;
    busy       = 1'b0;
    req_valid  = 4'hF;
    req_flowID = '0;
    req_meta   = '0;
    for (int p = 0; p < NP; p++) begin
      set_fid(p, FW'(p));
      req_meta[p*MW +: MW] = MW'(16'hA0 + p);
    end

    // Reset state, with every port requesting.
    #3;
    chk("rst_insert", 32'(insert), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_flow", 32'(flowID_out), 32'd0);
    chk("rst_meta", 32'(meta_out), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_icnt", insert_count, 32'd0);

    // All ports valid: rotation 0,1,2,3,0,... with one insert per cycle.
    cyc();
    rst = 1'b0;
    #1;
    chk("rot_ready0", 32'(req_ready), 32'h1);
    for (int k = 1; k < 8; k++) begin
      cyc();
      chk_ins("rot", FW'((k - 1) % 4));
      chk("rot_ready", 32'(req_ready), 32'(1 << (k % 4)));
    end
    cyc();
    chk_ins("rot_last", FW'(3));
    req_valid = '0;
    cyc();
    chk("rot_idle_insert", 32'(insert), 32'd0);
    chk("rot_icnt", insert_count, 32'd8);
    chk("rot_hold_flow", 32'(flowID_out), 32'd3);
    chk("rot_hold_meta", 32'(meta_out), 32'hA3);

    // Sparse requests: grant port 1 moves pointer to 2, then 3,1,3.
    req_valid = 4'b0010;
    #1;
    chk("sp_ready_a", 32'(req_ready), 32'b0010);
    cyc();
    chk_ins("sp_a", FW'(1));
    req_valid = 4'b1010;
    #1;
    chk("sp_ready_b", 32'(req_ready), 32'b1000);
    cyc();
    chk_ins("sp_b", FW'(3));
    chk("sp_ready_c", 32'(req_ready), 32'b0010);
    cyc();
    chk_ins("sp_c", FW'(1));
    chk("sp_ready_d", 32'(req_ready), 32'b1000);
    cyc();
    chk_ins("sp_d", FW'(3));
    req_valid = '0;
    cyc();
    chk("sp_icnt", insert_count, 32'd12);

    // Illegal flowID on port 2: accepted, dropped, counter saturates.
    set_fid(2, FW'(7));
    req_valid = 4'b0100;
    #1;
    chk("drop_ready", 32'(req_ready), 32'b0100);
    cyc();
    chk("drop_no_insert", 32'(insert), 32'd0);
    chk("drop_cnt1", 32'(drop_count), 32'd1);
    chk("drop_hold_flow", 32'(flowID_out), 32'd3);
    for (int k = 0; k < 65540; k++) begin
      cyc();
      if (insert) inserts_seen++;
    end
    req_valid = '0;
    cyc();
    chk("drop_sat", 32'(drop_count), 32'hFFFF);
    chk("drop_inserts", 32'(inserts_seen), 32'd0);
    chk("drop_icnt", insert_count, 32'd12);
    set_fid(2, FW'(2));

    // Backpressure: busy rises right after the grant to port 0.
    req_valid = 4'b0011;
    #1;
    chk("busy_ready_a", 32'(req_ready), 32'b0001);
    cyc();
    busy = 1'b1;
    #1;
    chk("busy_ready_b", 32'(req_ready), 32'd0);
    chk_ins("busy_a", FW'(0));
    cyc();
    chk("busy_ready_c", 32'(req_ready), 32'd0);
    chk("busy_no_insert", 32'(insert), 32'd0);
    busy = 1'b0;
    #1;
    chk("busy_ready_d", 32'(req_ready), 32'b0010);
    cyc();
    chk_ins("busy_b", FW'(1));
    req_valid = '0;
    cyc();
    chk("busy_icnt", insert_count, 32'd14);

    // Reset lands before a granted insert registers; pointer restarts at 0.
    req_valid = 4'b0100;
    #1;
    chk("rm_ready", 32'(req_ready), 32'b0100);
    #2;
    rst = 1'b1;
    cyc();
    chk("rm_insert", 32'(insert), 32'd0);
    chk("rm_icnt", insert_count, 32'd0);
    chk("rm_drop", 32'(drop_count), 32'd0);
    chk("rm_flow", 32'(flowID_out), 32'd0);
    req_valid = 4'hF;
    #1;
    chk("rm_ready_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rm_ready_rel", 32'(req_ready), 32'b0001);
    cyc();
    chk_ins("rm_first", FW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
